// File: rtl/quad_encoder_counter.sv
// Quadrature encoder counter: synchronizes and filters the A/B pins, counts
// steps into a 32-bit position, flags illegal transitions, and measures
// velocity as signed steps per WINDOW-cycle sample window.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   pinEncoderF/B      raw encoder channels A/B (asynchronous)
//   writeEncoder       one-cycle load strobe for setEncoderData
//   setEncoderData     position value to load
//   encoderValue       position count, two's complement, wraps mod 2^32
//   velocity           signed step count of the last completed window
//   velocity_valid     one-cycle pulse when velocity updates
//   dir                direction of the last valid step (1 = forward)
//   error              sticky illegal-transition flag
//   clear_error        clears error (an illegal step that same cycle wins)
module quad_encoder_counter #(
  parameter int FILTER_LEN = 4,
  parameter int WINDOW     = 16000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pinEncoderF,
  input  logic               pinEncoderB,
  input  logic               writeEncoder,
  input  logic [31:0]        setEncoderData,
  output logic [31:0]        encoderValue,
  output logic signed [15:0] velocity,
  output logic               velocity_valid,
  output logic               dir,
  output logic               error,
  input  logic               clear_error
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [4:0] INIT_LEN = 5'(FILTER_LEN + 2);
  localparam logic [3:0] FL = 4'(FILTER_LEN);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

  // bit 1 = channel A, bit 0 = channel B
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      prev_q, prev_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic [4:0]      init_q, init_d;
  logic            init_done;

  logic [31:0]        enc_q, enc_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic [WW-1:0]      win_q, win_d;
  logic signed [15:0] acc_q, acc_d;
  logic signed [15:0] vel_q, vel_d;
  logic               vv_q, vv_d;

  logic [1:0]         dpos;
  logic               fwd, bwd, illegal;
  logic               win_last;
  logic signed [16:0] step_w, sum_w;
  logic signed [15:0] sat_w;

  // Gray position of a filtered {A,B} pair along 00->10->11->01.
  function automatic logic [1:0] pos_of(input logic [1:0] ab);
    logic [1:0] p;
    unique case (ab)
      2'b00:   p = 2'd0;
      2'b10:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  assign init_done = (init_q == INIT_LEN);

  always_comb begin
    init_d = init_done ? init_q : init_q + 5'd1;
  end

  // During the init phase both filtered and previous levels follow the
  // synchronizer, so no step is seen when filtering takes over.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    prev_d = init_done ? filt_q : sync2_q;
    for (int i = 0; i < 2; i++) begin
      if (!init_done) begin
        filt_d[i] = sync2_q[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == FL) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Position difference mod 4: 1 forward, 3 backward, 2 both bits flipped.
  always_comb begin
    dpos    = pos_of(filt_q) - pos_of(prev_q);
    fwd     = init_done && (dpos == 2'd1);
    bwd     = init_done && (dpos == 2'd3);
    illegal = init_done && (dpos == 2'd2);
  end

  always_comb begin
    enc_d = enc_q;
    if (writeEncoder) begin
      enc_d = setEncoderData;
    end else if (fwd) begin
      enc_d = enc_q + 32'd1;
    end else if (bwd) begin
      enc_d = enc_q - 32'd1;
    end
    dir_d = fwd ? 1'b1 : (bwd ? 1'b0 : dir_q);
    err_d = illegal ? 1'b1 : (clear_error ? 1'b0 : err_q);
  end

  always_comb begin
    win_last = (win_q == WLAST);
    win_d    = win_last ? '0 : win_q + 1'b1;
    step_w   = fwd ? 17'sd1 : (bwd ? -17'sd1 : 17'sd0);
    sum_w    = {acc_q[15], acc_q} + step_w;
    if (sum_w > 17'sd32767) begin
      sat_w = 16'sh7FFF;
    end else if (sum_w < -17'sd32768) begin
      sat_w = -16'sh8000;
    end else begin
      sat_w = sum_w[15:0];
    end
    acc_d = win_last ? 16'sd0 : sat_w;
    vel_d = win_last ? sat_w : vel_q;
    vv_d  = win_last;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      fcnt_q  <= '0;
      init_q  <= '0;
      enc_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= '0;
      acc_q   <= '0;
      vel_q   <= '0;
      vv_q    <= 1'b0;
    end else begin
      sync1_q <= {pinEncoderF, pinEncoderB};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      fcnt_q  <= fcnt_d;
      init_q  <= init_d;
      enc_q   <= enc_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      vel_q   <= vel_d;
      vv_q    <= vv_d;
    end
  end

  assign encoderValue   = enc_q;
  assign velocity       = vel_q;
  assign velocity_valid = vv_q;
  assign dir            = dir_q;
  assign error          = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Testbench for quad_encoder_counter: vector table, directed corner
// sequences and random steps/loads against a step-schedule model.
module tb_quad_encoder_counter;
  localparam int FL = 4;
  localparam int W  = 100;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               pinF = 1'b1, pinB = 1'b1;
  logic               wr = 1'b0, clr = 1'b0;
  logic [31:0]        setd = '0;
  logic [31:0]        enc;
  logic signed [15:0] vel;
  logic               vv, dir, err;

  quad_encoder_counter #(.FILTER_LEN(FL), .WINDOW(W)) dut (
    .clk(clk), .resetn(resetn),
    .pinEncoderF(pinF), .pinEncoderB(pinB),
    .writeEncoder(wr), .setEncoderData(setd),
    .encoderValue(enc), .velocity(vel),
    .velocity_valid(vv), .dir(dir), .error(err),
    .clear_error(clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int steps_at[int];
  int pos = 2;
  logic [31:0] m_enc = '0;
  logic m_dir = 1'b0;

  // cyc = clock edges since reset release; DUT window counter == cyc mod W.
  always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

  typedef struct {
    int          op;
    logic [31:0] data;
    logic [31:0] exp_enc;
    logic        exp_dir;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Change pins one quadrature step; the count moves 7 edges later.
  task automatic step(input int d);
    pos = (pos + d) & 3;
    {pinF, pinB} = gray(pos);
    if (steps_at.exists(cyc + 6)) steps_at[cyc + 6] += d;
    else steps_at[cyc + 6] = d;
    m_enc = m_enc + 32'(d);
    m_dir = (d > 0);
  endtask

  task automatic load(input logic [31:0] v);
    setd = v;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    m_enc = v;
  endtask

  // Velocity monitor: every window end must pulse, with the saturated sum
  // of the steps the model scheduled inside that window.
  always @(negedge clk) begin
    logic ev;
    int s;
    ev = (cyc > 0) && (cyc % W == 0);
    if (vv || ev) begin
      checks++;
      if (vv !== ev) begin
        failures++;
        $display("FAIL velocity_valid: got %b expected %b at cyc %0d",
                 vv, ev, cyc);
      end else begin
        s = 0;
        for (int e = cyc - W; e < cyc; e++)
          if (steps_at.exists(e)) s += steps_at[e];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (vel !== 16'(s)) begin
          failures++;
          $display("FAIL velocity: got %0d expected %0d", vel, s);
        end
      end
    end
  end

  initial begin
    int c0, r, gap;
    for (int i = 0; i < 7; i++) tbl[i] = '{0, 0, 32'(i + 2), 1'b1};
    tbl[7]  = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{0, 0, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1, 0, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{1, 0, 32'hFFFF_FFFE, 1'b0};

    tick(3);
    resetn = 1'b1;
    steps_at.delete();
    tick(FL + 2 + 4);
    chk("init_enc", enc, 0);
    chk("init_err", {31'b0, err}, 0);

    step(1);
    tick(6);
    chk("latency_before", enc, 0);
    tick(1);
    chk("latency_at", enc, 1);
    tick(13);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: begin step(1); tick(20); end
        1: begin step(-1); tick(20); end
        default: begin load(tbl[i].data); tick(19); end
      endcase
      chk($sformatf("vec%0d_enc", i), enc, tbl[i].exp_enc);
      chk($sformatf("vec%0d_dir", i), {31'b0, dir}, {31'b0, tbl[i].exp_dir});
    end

    pinF = ~pinF;
    tick(3);
    pinF = ~pinF;
    tick(15);
    chk("glitch_enc", enc, 32'hFFFF_FFFE);
    chk("glitch_err", {31'b0, err}, 0);

    step(-1);
    tick(20);
    chk("pre_illegal_enc", enc, 32'hFFFF_FFFD);
    pos = 2;
    {pinF, pinB} = 2'b11;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("illegal_clear_same", {31'b0, err}, 1);
    tick(5);
    chk("illegal_sticky", {31'b0, err}, 1);
    chk("illegal_enc", enc, 32'hFFFF_FFFD);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clear_error", {31'b0, err}, 0);
    tick(10);

    step(1);
    tick(6);
    load(32'hA5A5_0001);
    chk("load_vs_step_enc", enc, 32'hA5A5_0001);
    chk("load_vs_step_dir", {31'b0, dir}, 1);
    tick(15);
    chk("load_vs_step_hold", enc, 32'hA5A5_0001);

    for (int k = 0; k < W && (cyc % W) != 0; k++) tick(1);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) load(32'h0000_1234);
      else tick(1);
      step(1);
      tick(7);
    end
    tick(c0 + W - cyc);
    chk("window_valid", {31'b0, vv}, 1);
    chk("window_velocity", {16'b0, vel}, 10);
    chk("window_enc", enc, 32'h0000_123A);
    tick(1);
    chk("window_pulse_end", {31'b0, vv}, 0);

    tick(20);
    pos = (pos + 2) & 3;
    {pinF, pinB} = gray(pos);
    tick(10);
    chk("pre_reset_err", {31'b0, err}, 1);
    step(1);
    tick(3);
    resetn = 1'b0;
    tick(2);
    chk("reset_enc", enc, 0);
    chk("reset_vel", {16'b0, vel}, 0);
    chk("reset_vv", {31'b0, vv}, 0);
    chk("reset_dir", {31'b0, dir}, 0);
    chk("reset_err", {31'b0, err}, 0);
    steps_at.delete();
    m_enc = '0;
    m_dir = 1'b0;
    resetn = 1'b1;
    tick(W + 20);
    chk("post_reset_enc", enc, 0);
    chk("post_reset_err", {31'b0, err}, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      gap = $urandom_range(9, 25);
      if (r < 4) step(1);
      else if (r < 8) step(-1);
      else if (r == 8) begin load($urandom); gap = gap - 1; end
      tick(gap);
      chk($sformatf("rand%0d_enc", i), enc, m_enc);
      chk($sformatf("rand%0d_dir", i), {31'b0, dir}, {31'b0, m_dir});
    end
    chk("rand_err", {31'b0, err}, 0);

    tick(W + 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive stable clock cycles required before a pin level is accepted (range 1..15).
REQ-002 SHALL have parameter WINDOW, default 16000, meaning velocity sample window in clk cycles (1 ms at 16 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port pinEncoderF  input  1  encoder channel A, asynchronous to clk.
REQ-006 SHALL have port pinEncoderB  input  1  encoder channel B, asynchronous to clk.
REQ-007 SHALL have port writeEncoder  input  1  single-cycle position load strobe.
REQ-008 SHALL have port setEncoderData  input  32  position value to load.
REQ-009 SHALL have port encoderValue  output  32  position count, two's complement.
REQ-010 SHALL have port velocity  output  16  signed counts in the last completed window.
REQ-011 SHALL have port velocity_valid  output  1  one-cycle pulse when velocity updates.
REQ-012 SHALL have port dir  output  1  direction of the last valid step; 1 = forward.
REQ-013 SHALL have port error  output  1  sticky illegal-transition flag.
REQ-014 SHALL have port clear_error  input  1  clears error.

Function
REQ-015 SHALL pass each pin through a 2-flop synchronizer before any other logic.
REQ-016 SHALL, per channel, count consecutive cycles where the synchronized level differs from the filtered level, reset the count on any agreement, and update the filtered level when the count reaches FILTER_LEN.
REQ-017 SHALL decode the filtered pair {A,B}: 00->10->11->01->00 is a forward step (+1); the reverse sequence is a backward step (-1); no change is no step.
REQ-018 SHALL treat a simultaneous change of both filtered bits as illegal: no step, error set to 1 the next cycle.
REQ-019 SHALL update encoderValue one cycle after the filtered level changes, giving a total pin-edge-to-count latency of 2 + FILTER_LEN + 1 cycles.
REQ-020 SHALL wrap encoderValue modulo 2^32 (0xFFFFFFFF +1 -> 0; 0 -1 -> 0xFFFFFFFF).
REQ-021 SHALL, when writeEncoder=1, set encoderValue to setEncoderData on the next edge.
REQ-022 SHALL, when a load and a step coincide, give the load priority and discard the step from encoderValue only.
REQ-023 SHALL set dir on every valid step, and hold dir otherwise.
REQ-024 SHALL, when clear_error=1, clear error; if clear_error and an illegal transition coincide, error SHALL remain 1.
REQ-025 SHALL run a window counter 0..WINDOW-1 that wraps, and accumulate steps into a signed 16-bit accumulator saturating at +32767 and -32768.
REQ-026 SHALL, on the last window cycle, latch accumulator plus that cycle's step (saturated) into velocity, pulse velocity_valid for one cycle, and restart the accumulator at 0.
REQ-027 SHALL exclude loads from velocity accounting; steps discarded by REQ-022 still count toward velocity.

Reset
REQ-028 SHALL, while resetn=0 at a clk edge, set encoderValue=0, velocity=0, velocity_valid=0, dir=0, error=0, window counter=0, accumulator=0, filter counts=0.
REQ-029 SHALL, for the first FILTER_LEN+2 cycles after reset release, let filtered levels track the synchronized inputs directly, with no steps and no errors generated.
REQ-030 SHALL, on reset asserted mid-window or mid-filter, abandon all partial state without producing velocity_valid.

Verification
REQ-031 Pins idle at 11 through reset release -> encoderValue=0, error=0 after the init phase.
REQ-032 With FILTER_LEN=4, apply 8 clean forward quadrature edges spaced 20 cycles apart -> encoderValue=8, dir=1; the first count change occurs exactly 7 cycles after the first pin edge.
REQ-033 Apply a 3-cycle glitch on channel A -> no count change and error=0.
REQ-034 Load 0xFFFFFFFF, then apply 1 forward step -> 0x00000000; apply 2 backward steps -> 0xFFFFFFFE, dir=0.
REQ-035 With WINDOW=100, apply 10 forward steps in one window -> velocity=10 with a single velocity_valid pulse at window end; a load of 0x1234 in the same window leaves velocity=10.
REQ-036 Switch both pins 00->11 together -> error=1, no count; assert clear_error -> error=0 the next cycle.
